// File: rtl/calc_pkg.sv
// Shared opcodes, FSM encoding and default width for the calculator front end.
package calc_pkg;

  localparam int W_DEF = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/calc_iter_div.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, W cycles.
module calc_iter_div
  import calc_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dsr_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [W:0]    trial;
  logic          ge;

  // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
  assign trial = {rem_q, quo_q[W-1]};
  assign ge    = trial >= {1'b0, dsr_q};
  assign rem_d = ge ? W'(trial - {1'b0, dsr_q}) : trial[W-1:0];
  assign quo_d = {quo_q[W-2:0], ge};

  // Outputs present the final iteration's result in the same cycle done is high.
  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CW'(1));
  assign quotient  = quo_d;
  assign remainder = rem_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dsr_q  <= divisor;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_scheduler.sv
// Round-robin two-requester front end for the add/sub/mul/div calculator datapath.
module calc_scheduler
  import calc_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [1:0]     req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [1:0]     req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_result,
  output logic [W-1:0]   rsp_remainder,
  output logic           rsp_error
);

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           rsp_id_q, rsp_id_d;
  logic [2*W-1:0] rsp_result_q, rsp_result_d;
  logic [W-1:0]   rsp_rem_q, rsp_rem_d;
  logic           rsp_err_q, rsp_err_d;

  logic           gnt0, gnt1, acc;
  logic [W-1:0]   sel_a, sel_b;
  logic [1:0]     sel_op;
  logic [2*W-1:0] add_res, sub_res, mul_res;
  logic           div_start, div_busy, div_done;
  logic [W-1:0]   div_quo, div_rem;

  // prio_q = 1 means requester 1 wins a tie.
  assign gnt0 = req0_valid & (~req1_valid | ~prio_q);
  assign gnt1 = req1_valid & (~req0_valid | prio_q);
  assign acc  = (state_q == IDLE) & (gnt0 | gnt1);

  assign sel_a  = gnt1 ? req1_a  : req0_a;
  assign sel_b  = gnt1 ? req1_b  : req0_b;
  assign sel_op = gnt1 ? req1_op : req0_op;

  assign add_res = (2*W)'(sel_a) + (2*W)'(sel_b);
  assign sub_res = (2*W)'(sel_a) - (2*W)'(sel_b);
  assign mul_res = (2*W)'(sel_a) * (2*W)'(sel_b);

  assign div_start = acc & (sel_op == OP_DIV) & (sel_b != '0);

  calc_iter_div #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (sel_a),
    .divisor   (sel_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          prio_d    = gnt0;
          rsp_id_d  = gnt1;
          rsp_rem_d = '0;
          rsp_err_d = 1'b0;
          state_d   = RESP;
          case (sel_op)
            OP_ADD: rsp_result_d = add_res;
            OP_SUB: rsp_result_d = sub_res;
            OP_MUL: rsp_result_d = mul_res;
            default: begin
              rsp_result_d = '0;
              if (sel_b == '0) rsp_err_d = 1'b1;
              else             state_d   = DIV;
            end
          endcase
        end
      end
      DIV: begin
        if (div_done) begin
          rsp_result_d = (2*W)'(div_quo);
          rsp_rem_d    = div_rem;
          state_d      = RESP;
        end else if (!div_busy) begin
          // Divider lost its operation without finishing; recover rather than hang.
          state_d = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_rem_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready    = (state_q == IDLE) & gnt0;
  assign req1_ready    = (state_q == IDLE) & gnt1;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_error     = rsp_err_q;

endmodule

// File: tb/tb_calc_scheduler.sv
// Scoreboard bench for calc_scheduler: directed ops push expectations, a monitor checks responses.
module tb_calc_scheduler;

  localparam int W = 8;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DVD = 2'b11;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [1:0]     req0_op, req1_op;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_error;
  logic [2*W-1:0] rsp_result;
  logic [W-1:0]   rsp_remainder;

  calc_scheduler #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_remainder(rsp_remainder), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    bit             id;
    logic [2*W-1:0] res;
    logic [W-1:0]   rem;
    bit             err;
    int             acc;
    int             lat;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: latency is measured from accept to the first cycle rsp_valid is seen.
  bit   in_rsp = 1'b0;
  int   rsp_start = 0;
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        in_rsp    = 1'b1;
        rsp_start = cyc;
      end
      if (rsp_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d result 0x%0h with no expectation", rsp_id, rsp_result);
        end else begin
          me = sbq.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(me.id));
          chk("rsp_result", 32'(rsp_result), 32'(me.res));
          chk("rsp_remainder", 32'(rsp_remainder), 32'(me.rem));
          chk("rsp_error", 32'(rsp_error), 32'(me.err));
          chk("rsp_latency", 32'(rsp_start - me.acc), 32'(me.lat));
        end
        in_rsp = 1'b0;
      end
    end else begin
      in_rsp = 1'b0;
    end
  end

  // Called and returns at posedge+1; holds valid until accepted.
  task automatic issue(input bit id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] res, input logic [W-1:0] rem, input bit err,
                       input int lat, input bit expect_rsp);
    bit   got = 1'b0;
    exp_t e;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      e.id = id; e.res = res; e.rem = rem; e.err = err; e.acc = cyc; e.lat = lat;
      if (expect_rsp) sbq.push_back(e);
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req%0d never got ready", id);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still pending", sbq.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int last_acc;
    bit got;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = ADD;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = ADD;
    do_reset();

    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_rsp_result", 32'(rsp_result), 0);
    chk("reset_rsp_remainder", 32'(rsp_remainder), 0);
    chk("reset_rsp_error", 32'(rsp_error), 0);
    chk("reset_ready0_idle", 32'(req0_ready), 0);
    @(posedge clk); #1;

    // Single-cycle ops
    issue(0, ADD, 8'd200, 8'd100, 16'h012C, 8'd0, 0, 1, 1); wait_drain();
    issue(0, SUB, 8'd3,   8'd5,   16'hFFFE, 8'd0, 0, 1, 1); wait_drain();
    issue(1, MUL, 8'd255, 8'd255, 16'hFE01, 8'd0, 0, 1, 1); wait_drain();
    issue(1, ADD, 8'd255, 8'd255, 16'h01FE, 8'd0, 0, 1, 1); wait_drain();

    // Round robin with both requesters permanently valid, from reset priority
    do_reset();
    req0_a = 8'd10; req0_b = 8'd20; req0_op = ADD;
    req1_a = 8'd6;  req1_b = 8'd7;  req1_op = MUL;
    req0_valid = 1'b1; req1_valid = 1'b1;
    last_acc = 0;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin got = 1'b1; break; end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL rr_timeout: no grant for op %0d", k);
        break;
      end
      chk("rr_grant_id", 32'(req1_ready), 32'(k % 2));
      chk("rr_single_grant", 32'(req0_ready & req1_ready), 0);
      if (k > 0) chk("rr_spacing", 32'(cyc - last_acc), 2);
      last_acc = cyc;
      e.id = bit'(k % 2); e.res = (k % 2) ? 16'd42 : 16'd30; e.rem = '0; e.err = 0;
      e.acc = cyc; e.lat = 1;
      sbq.push_back(e);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    // Divides
    issue(1, DVD, 8'd200, 8'd7,   16'd28,  8'd4, 0, W + 1, 1); wait_drain();
    issue(0, DVD, 8'd7,   8'd200, 16'd0,   8'd7, 0, W + 1, 1); wait_drain();
    issue(0, DVD, 8'd255, 8'd1,   16'd255, 8'd0, 0, W + 1, 1); wait_drain();
    issue(1, DVD, 8'd9,   8'd0,   16'd0,   8'd0, 1, 1,     1); wait_drain();

    // Backpressure: response must hold and requesters stay blocked
    rsp_ready = 1'b0;
    issue(0, MUL, 8'd12, 8'd13, 16'd156, 8'd0, 0, 1, 1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_result", 32'(rsp_result), 156);
      chk("bp_rsp_id", 32'(rsp_id), 0);
      chk("bp_ready0", 32'(req0_ready), 0);
      chk("bp_ready1", 32'(req1_ready), 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a divide drops it and restores priority to requester 0
    issue(0, DVD, 8'd100, 8'd3, 16'd33, 8'd1, 0, W + 1, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("div_ready0_blocked", 32'(req0_ready), 0);
    chk("div_ready1_blocked", 32'(req1_ready), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_div_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_div_ready0", 32'(req0_ready), 1);
    chk("rst_div_ready1", 32'(req1_ready), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      chk("rst_div_no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk); #1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
